uart_wb_master: RTL and testbench

- Debug/boot bridge: decodes a byte-oriented command stream from a UART receiver core and issues single Wishbone read/write transactions as bus initiator.
- Returns results as bytes to a UART transmitter core.
- Sits between the UART_RX/UART_TX bit-level cores and the system bus, so a host PC can peek/poke any Wishbone slave (including the UART peripheral's registers).

---
 rtl/uart_wb_pkg.sv | 26 ++
 rtl/uart_wb_master.sv | 183 ++++++++++++++++++
 tb/tb_uart_wb_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge.
// Holds the FSM state encoding, the default command/response bytes and a
// constant helper used to size the shared timeout counter.
package uart_wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP,
    S_TX_SEND,
    S_TX_GAP,
    S_TX_WAIT
  } state_t;

  localparam logic [7:0] CMD_WRITE_DEF = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ_DEF  = 8'h52;  // 'R'
  localparam logic [7:0] RESP_OK_DEF   = 8'h4B;  // 'K'
  localparam logic [7:0] RESP_ERR_DEF  = 8'h45;  // 'E'

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_wb_master.sv
// uart_wb_master: decodes byte commands from a UART receiver and runs single
// Wishbone read/write cycles, answering through a UART transmitter.
//   Write frame: CMD_WRITE A3 A2 A1 A0 D3 D2 D1 D0  -> reply RESP_OK
//   Read frame : CMD_READ  A3 A2 A1 A0              -> reply D3 D2 D1 D0
//   Bus timeout                                     -> reply RESP_ERR
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_valid_i/rx_data_i received byte strobe and value
//   tx_en_o/tx_data_o   transmit start pulse and byte, tx_busy_i from the TX core
//   cyc_o/stb_o/we_o/addr_o/data_o  Wishbone initiator outputs
//   data_i/ack_i        Wishbone read data and acknowledge
//   busy_o              high whenever a command is in progress
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int         BUS_TIMEOUT   = 1024,
  parameter int         FRAME_TIMEOUT = 250000,
  parameter logic [7:0] CMD_WRITE     = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ      = CMD_READ_DEF,
  parameter logic [7:0] RESP_OK       = RESP_OK_DEF,
  parameter logic [7:0] RESP_ERR      = RESP_ERR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_en_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic        ack_i,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(max_int(BUS_TIMEOUT, FRAME_TIMEOUT) + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_bcnt;
  logic               r_we;
  logic               r_err;
  logic               r_cyc;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_txq;
  logic [1:0]         r_left;

  logic w_last_byte;
  logic w_bus_to;
  logic w_frame_to;
  logic w_in_frame;

  assign w_last_byte = (r_bcnt == 2'd3);
  assign w_bus_to    = (r_cnt == CNT_W'(BUS_TIMEOUT - 1));
  assign w_frame_to  = (r_cnt == CNT_W'(FRAME_TIMEOUT - 1));
  assign w_in_frame  = (r_state == S_ADDR) || (r_state == S_DATA);

  // cyc and stb are one flop, so stb can never appear without cyc.
  assign cyc_o     = r_cyc;
  assign stb_o     = r_cyc;
  assign we_o      = r_we;
  assign addr_o    = r_addr;
  assign data_o    = r_wdata;
  assign tx_data_o = r_txq[31:24];
  assign busy_o    = (r_state != S_IDLE);
  // Combinational so the pulse appears in the first TX_SEND cycle with the
  // transmitter idle (two cycles after ack).
  assign tx_en_o   = (r_state == S_TX_SEND) && !tx_busy_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_valid_i && ((rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ)))
          w_next = S_ADDR;
      end
      S_ADDR: begin
        // A byte arriving on the expiry cycle still counts.
        if (rx_valid_i) begin
          if (w_last_byte) w_next = r_we ? S_DATA : S_BUS;
        end else if (w_frame_to) begin
          w_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid_i) begin
          if (w_last_byte) w_next = S_BUS;
        end else if (w_frame_to) begin
          w_next = S_IDLE;
        end
      end
      S_BUS: begin
        if (ack_i || w_bus_to) w_next = S_RESP;
      end
      S_RESP:    w_next = S_TX_SEND;
      S_TX_SEND: if (!tx_busy_i) w_next = S_TX_GAP;
      S_TX_GAP:  w_next = S_TX_WAIT;
      S_TX_WAIT: begin
        if (!tx_busy_i) w_next = (r_left == 2'd0) ? S_IDLE : S_TX_SEND;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_txq   <= '0;
      r_left  <= '0;
    end else begin
      r_state <= w_next;
      r_cyc   <= (w_next == S_BUS);

      // One counter serves both the inter-byte and the bus-ack timeouts.
      if ((w_next != r_state) || (w_in_frame && rx_valid_i))
        r_cnt <= '0;
      else if (w_in_frame || (r_state == S_BUS))
        r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (w_next == S_ADDR) begin
            r_we   <= (rx_data_i == CMD_WRITE);
            r_bcnt <= 2'd0;
            r_err  <= 1'b0;
          end
        end
        S_ADDR: begin
          if (rx_valid_i) begin
            r_addr <= {r_addr[23:0], rx_data_i};
            r_bcnt <= r_bcnt + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_valid_i) begin
            r_wdata <= {r_wdata[23:0], rx_data_i};
            r_bcnt  <= r_bcnt + 2'd1;
          end
        end
        S_BUS: begin
          // Read data lands directly in the response queue.
          if (ack_i) begin
            if (!r_we) r_txq <= data_i;
          end else if (w_bus_to) begin
            r_err <= 1'b1;
          end
        end
        S_RESP: begin
          if (r_err) begin
            r_txq  <= {RESP_ERR, 24'h0};
            r_left <= 2'd0;
          end else if (r_we) begin
            r_txq  <= {RESP_OK, 24'h0};
            r_left <= 2'd0;
          end else begin
            r_left <= 2'd3;
          end
        end
        S_TX_WAIT: begin
          if (!tx_busy_i && (r_left != 2'd0)) begin
            r_txq  <= {r_txq[23:0], 8'h00};
            r_left <= r_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
module tb_uart_wb_master;
  localparam int BT = 64;
  localparam int FT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        tx_en_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i = 1'b0;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] addr_o, data_o;
  logic [31:0] data_i = 32'h0;
  logic        ack_i = 1'b0;
  logic        busy_o;

  int n_checks = 0;
  int n_err = 0;

  // Slave / transmitter model state
  int          cyc_no = 0;
  int          bus_wait = 0;
  int          cyc_len = 0;
  int          n_bus = 0;
  int          ack_delay = 3;
  logic        ack_en = 1'b1;
  logic [31:0] slave_rdata = 32'h0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_addr = 32'h0, cap_data = 32'h0;
  int          ack_cyc = 0;
  int          tx_first = 0;
  int          tx_hold = 0;
  logic        tx_pend = 1'b0;
  int          tx_viol = 0;
  int          stb_viol = 0;
  logic [7:0]  txq[$];

  uart_wb_master #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_en_o(tx_en_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
    .ack_i(ack_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Bus slave and UART transmitter models, driven mid-cycle on the falling edge.
  always @(negedge clk) begin
    cyc_no++;
    if (tx_en_o) begin
      if (txq.size() == 0) tx_first = cyc_no;
      if (tx_busy_i) tx_viol++;
      txq.push_back(tx_data_o);
    end
    if (tx_hold != 0) begin
      tx_hold--;
      if (tx_hold == 0) tx_busy_i = 1'b0;
    end else if (tx_pend) begin
      tx_pend = 1'b0;
      tx_busy_i = 1'b1;
      tx_hold = 4;
    end
    if (tx_en_o) tx_pend = 1'b1;

    if (cyc_o) begin
      if (stb_o !== 1'b1) stb_viol++;
      bus_wait++;
      if (bus_wait == 1) begin
        n_bus++;
        cap_we = we_o;
        cap_addr = addr_o;
        cap_data = data_o;
      end
      if (ack_en && bus_wait == ack_delay) begin
        ack_i = 1'b1;
        data_i = slave_rdata;
        ack_cyc = cyc_no;
      end else begin
        ack_i = 1'b0;
        data_i = 32'h0;
      end
      cyc_len = bus_wait;
    end else begin
      if (stb_o !== 1'b0) stb_viol++;
      bus_wait = 0;
      ack_i = 1'b0;
      data_i = 32'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tx_b(input int i);
    if (txq.size() > i) return txq[i];
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i = b;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[9], input int n);
    for (int i = 0; i < n; i++) send_byte(b[i]);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (busy_o && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int nb;
    #1;
    check("rst_cyc", 32'(cyc_o), 32'd0);
    check("rst_stb", 32'(stb_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_txen", 32'(tx_en_o), 32'd0);
    check("rst_txdata", 32'(tx_data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Write with ack after 3 cycles
    txq.delete();
    ack_en = 1'b1; ack_delay = 3;
    nb = n_bus;
    send_frame('{8'h57, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 9);
    check("wr_cyc_latency", 32'(cyc_o), 32'd1);
    wait_idle("wr_idle", 500);
    check("wr_nbus", 32'(n_bus - nb), 32'd1);
    check("wr_we", 32'(cap_we), 32'd1);
    check("wr_addr", cap_addr, 32'h00001004);
    check("wr_data", cap_data, 32'hDEADBEEF);
    check("wr_cyclen", 32'(cyc_len), 32'd3);
    check("wr_ntx", 32'(txq.size()), 32'd1);
    check("wr_tx0", 32'(tx_b(0)), 32'h4B);

    // Read returning 0x12345678
    txq.delete();
    slave_rdata = 32'h12345678; ack_delay = 2;
    send_frame('{8'h52, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    wait_idle("rd_idle", 500);
    check("rd_we", 32'(cap_we), 32'd0);
    check("rd_addr", cap_addr, 32'h00001000);
    check("rd_ntx", 32'(txq.size()), 32'd4);
    check("rd_tx0", 32'(tx_b(0)), 32'h12);
    check("rd_tx1", 32'(tx_b(1)), 32'h34);
    check("rd_tx2", 32'(tx_b(2)), 32'h56);
    check("rd_tx3", 32'(tx_b(3)), 32'h78);
    check("rd_ack_to_txen", 32'(tx_first - ack_cyc), 32'd2);

    // Read with no ack: bus timeout, stray byte during BUS ignored
    txq.delete();
    ack_en = 1'b0;
    nb = n_bus;
    send_frame('{8'h52, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    repeat (5) @(negedge clk);
    send_byte(8'h57);
    wait_idle("to_idle", 500);
    check("to_addr", cap_addr, 32'h80000000);
    check("to_cyclen", 32'(cyc_len), 32'(BT));
    check("to_nbus", 32'(n_bus - nb), 32'd1);
    check("to_ntx", 32'(txq.size()), 32'd1);
    check("to_tx0", 32'(tx_b(0)), 32'h45);
    repeat (2) @(negedge clk);
    check("to_stray_ignored", 32'(busy_o), 32'd0);

    // Unknown byte dropped, then a write
    txq.delete();
    ack_en = 1'b1; ack_delay = 1;
    send_byte(8'h41);
    check("junk_busy", 32'(busy_o), 32'd0);
    send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01}, 9);
    wait_idle("wr2_idle", 500);
    check("wr2_addr", cap_addr, 32'h00000008);
    check("wr2_data", cap_data, 32'h00000001);
    check("wr2_tx0", 32'(tx_b(0)), 32'h4B);

    // Partial frame discarded after FRAME_TIMEOUT idle cycles
    txq.delete();
    nb = n_bus;
    send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    repeat (FT - 10) @(negedge clk);
    check("ft_still_busy", 32'(busy_o), 32'd1);
    repeat (15) @(negedge clk);
    check("ft_dropped", 32'(busy_o), 32'd0);
    check("ft_nobus", 32'(n_bus - nb), 32'd0);
    check("ft_notx", 32'(txq.size()), 32'd0);
    slave_rdata = 32'hCAFEF00D; ack_delay = 2;
    send_frame('{8'h52, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    wait_idle("ft_rd_idle", 500);
    check("ft_rd_addr", cap_addr, 32'h0000000C);
    check("ft_rd_ntx", 32'(txq.size()), 32'd4);
    check("ft_rd_tx0", 32'(tx_b(0)), 32'hCA);
    check("ft_rd_tx3", 32'(tx_b(3)), 32'h0D);

    // Asynchronous reset in the middle of a read bus cycle
    txq.delete();
    ack_en = 1'b0;
    send_frame('{8'h52, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    begin
      int k;
      k = 0;
      while (!cyc_o && k < 20) begin @(negedge clk); k++; end
    end
    check("ar_cyc_before", 32'(cyc_o), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ar_cyc", 32'(cyc_o), 32'd0);
    check("ar_stb", 32'(stb_o), 32'd0);
    check("ar_txen", 32'(tx_en_o), 32'd0);
    check("ar_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1; ack_delay = 1;
    send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h20, 8'hA5, 8'h5A, 8'h00, 8'hFF}, 9);
    wait_idle("ar_wr_idle", 500);
    check("ar_wr_we", 32'(cap_we), 32'd1);
    check("ar_wr_addr", cap_addr, 32'h00000020);
    check("ar_wr_data", cap_data, 32'hA55A00FF);
    check("ar_wr_ntx", 32'(txq.size()), 32'd1);
    check("ar_wr_tx0", 32'(tx_b(0)), 32'h4B);

    check("tx_en_while_busy", 32'(tx_viol), 32'd0);
    check("stb_without_cyc", 32'(stb_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
